// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with per-entry busy scoreboard, write bypass and debug read
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ready,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W:0]   busy_count
);
    localparam int NREG = 1 << ADDR_W;
    localparam bit ZR   = (ZERO_REG != 0);
    localparam bit BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] rf_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   busy_count_q, busy_count_d;

    logic zero1, zero2, zero_rsv, zero_w, zero_dbg;
    logic byp1, byp2, rsv_fire;

    assign zero1    = ZR && (raddr1 == '0);
    assign zero2    = ZR && (raddr2 == '0);
    assign zero_rsv = ZR && (rsv_addr == '0);
    assign zero_w   = ZR && (waddr == '0);
    assign zero_dbg = ZR && (dbg_addr == '0);
    assign byp1     = BYP && wen && (waddr == raddr1);
    assign byp2     = BYP && wen && (waddr == raddr2);

    assign rdata1 = zero1 ? '0 : (byp1 ? wdata : rf_q[raddr1]);
    assign rdata2 = zero2 ? '0 : (byp2 ? wdata : rf_q[raddr2]);
    assign rbusy1 = busy_q[raddr1] && !byp1 && !zero1;
    assign rbusy2 = busy_q[raddr2] && !byp2 && !zero2;
    assign dbg_data = zero_dbg ? '0 : rf_q[dbg_addr];

    assign rsv_ready  = !flush && (!busy_q[rsv_addr] || zero_rsv);
    assign rsv_fire   = rsv_valid && rsv_ready && !zero_rsv;
    assign busy_count = busy_count_q;

    // Clear before set so a same-index writeback and new reservation leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wen)      busy_d[waddr]    = 1'b0;
        if (rsv_fire) busy_d[rsv_addr] = 1'b1;
        if (flush)    busy_d           = '0;
    end

    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < NREG; i++)
            busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            busy_count_q <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            if (wen && !zero_w) rf_q[waddr] <= wdata;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  raddr1, raddr2, rsv_addr, waddr, dbg_addr;
    logic [31:0] rdata1, rdata2, wdata, dbg_data;
    logic        rbusy1, rbusy2, rsv_valid, rsv_ready, wen, flush;
    logic [5:0]  busy_count;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .flush(flush),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; rsv_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        raddr1 = '0; raddr2 = '0; rsv_addr = '0; waddr = '0; dbg_addr = '0;
        wdata = '0; idle();
        #12;
        check("rst_rdata1", rdata1, 0);
        check("rst_rbusy1", rbusy1, 0);
        check("rst_count", busy_count, 0);
        check("rst_ready", rsv_ready, 1);
        check("rst_dbg", dbg_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic write with bypass
        wen = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr1 = 5; raddr2 = 5; dbg_addr = 5;
        #1;
        check("byp_rdata2", rdata2, 32'hDEADBEEF);
        check("dbg_old", dbg_data, 0);
        tick(); idle();
        #1;
        check("wr_rdata1", rdata1, 32'hDEADBEEF);
        check("dbg_new", dbg_data, 32'hDEADBEEF);

        // register zero
        wen = 1; waddr = 0; wdata = 32'h1234; rsv_valid = 1; rsv_addr = 0; raddr1 = 0;
        #1;
        check("x0_rdata1", rdata1, 0);
        check("x0_rbusy1", rbusy1, 0);
        check("x0_ready", rsv_ready, 1);
        tick(); idle(); dbg_addr = 0;
        #1;
        check("x0_count", busy_count, 0);
        check("x0_dbg", dbg_data, 0);

        // scoreboard reserve and writeback
        rsv_valid = 1; rsv_addr = 7;
        #1;
        check("sb_ready_idle", rsv_ready, 1);
        tick(); idle(); raddr1 = 7;
        #1;
        check("sb_rbusy1", rbusy1, 1);
        check("sb_ready_busy", rsv_ready, 0);
        check("sb_count1", busy_count, 1);
        wen = 1; waddr = 7; wdata = 32'h55;
        #1;
        check("sb_wb_rbusy1", rbusy1, 0);
        check("sb_wb_rdata1", rdata1, 32'h55);
        tick(); idle();
        #1;
        check("sb_count0", busy_count, 0);
        check("sb_rbusy1_after", rbusy1, 0);

        // simultaneous writeback and reserve of same index
        wen = 1; waddr = 3; wdata = 32'hA5A5; rsv_valid = 1; rsv_addr = 3;
        #1;
        check("sim_ready", rsv_ready, 1);
        tick(); idle(); raddr1 = 3;
        #1;
        check("sim_rdata1", rdata1, 32'hA5A5);
        check("sim_rbusy1", rbusy1, 1);
        check("sim_count", busy_count, 1);
        rsv_valid = 1; rsv_addr = 4; flush = 1; wen = 1; waddr = 9; wdata = 32'h99;
        #1;
        check("flush_ready", rsv_ready, 0);
        tick(); idle(); raddr2 = 4; dbg_addr = 9;
        #1;
        check("flush_count", busy_count, 0);
        check("flush_rbusy2", rbusy2, 0);
        check("flush_rbusy1", rbusy1, 0);
        check("flush_wdata", dbg_data, 32'h99);

        // fill every non-zero index
        for (int i = 1; i < 32; i++) begin
            rsv_valid = 1; rsv_addr = 5'(i);
            tick();
        end
        idle();
        #1;
        check("fill_count", busy_count, 31);
        rsv_addr = 31;
        #1;
        check("fill_ready31", rsv_ready, 0);
        rsv_valid = 1; rsv_addr = 0;
        #1;
        check("fill_ready0", rsv_ready, 1);
        tick(); rsv_addr = 10;
        tick(); idle();
        #1;
        check("fill_nowrap", busy_count, 31);

        // asynchronous reset between edges
        raddr1 = 10; raddr2 = 5; dbg_addr = 5;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", busy_count, 0);
        check("arst_rbusy1", rbusy1, 0);
        check("arst_rdata2", rdata2, 0);
        check("arst_dbg", dbg_data, 0);
        wen = 1; waddr = 6; wdata = 32'h66; rsv_valid = 1; rsv_addr = 6;
        tick();
        dbg_addr = 6;
        #1;
        check("arst_nowrite", dbg_data, 0);
        check("arst_norsv", busy_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); rsv_valid = 1; rsv_addr = 2;
        tick(); idle();
        #1;
        check("post_rst_rsv", busy_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
